// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: primary/secondary result inputs and the regfile write port.
interface wb_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
);
  logic          pri_we;
  logic [AW-1:0] pri_wa;
  logic [DW-1:0] pri_wd;
  logic          sec_valid;
  logic          sec_ready;
  logic [AW-1:0] sec_wa;
  logic [DW-1:0] sec_wd;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  modport master (
    output pri_we, pri_wa, pri_wd, sec_valid, sec_wa, sec_wd,
    input  sec_ready, we3, wa3, wd3
  );

  modport slave (
    input  pri_we, pri_wa, pri_wd, sec_valid, sec_wa, sec_wd,
    output sec_ready, we3, wa3, wd3
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: primary WB results win, secondary results queue in a FIFO.
// Optional WB_SCOREBOARD_EN builds the pending-register scoreboard; otherwise pending is 0.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_arbiter_if.slave              bus,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [14:0]              pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] PC_REG = AW'(15);

  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    wa_q [DEPTH];
  logic [AW-1:0]    wa_d [DEPTH];
  logic [DW-1:0]    wd_q [DEPTH];
  logic [DW-1:0]    wd_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we3_q, we3_d;
  logic [AW-1:0]    wa3_q, wa3_d;
  logic [DW-1:0]    wd3_q, wd3_d;

  logic sec_ready;
  logic push;
  logic pri_grant;
  logic pop;

  always_comb begin
    sec_ready = !reset && (cnt_q < CW'(DEPTH));
    push      = bus.sec_valid && sec_ready;
    pri_grant = bus.pri_we && (bus.pri_wa != PC_REG);
    pop       = !pri_grant && (cnt_q != '0);
  end

  always_comb begin
    live_d   = live_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;

    if (pri_grant) begin
      we3_d = 1'b1;
      wa3_d = bus.pri_wa;
      wd3_d = bus.pri_wd;
      // Queued results to the same register are older; kill them but keep their slot.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wa_q[i] == bus.pri_wa) live_d[i] = 1'b0;
      end
    end else if (pop) begin
      we3_d            = live_q[rd_ptr_q];
      wa3_d            = wa_q[rd_ptr_q];
      wd3_d            = wd_q[rd_ptr_q];
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end

    // Enqueue after the kill so a same-cycle secondary result stays live.
    if (push) begin
      live_d[wr_ptr_q] = (bus.sec_wa != PC_REG);
      wa_d[wr_ptr_q]   = bus.sec_wa;
      wd_d[wr_ptr_q]   = bus.sec_wd;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by live/count.
  always_ff @(posedge clk) begin
    wa_q <= wa_d;
    wd_q <= wd_d;
  end

  assign bus.sec_ready = sec_ready;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign fifo_cnt      = cnt_q;

`ifdef WB_SCOREBOARD_EN
  logic [14:0] pending_q, pending_d;

  always_comb begin
    pending_d = '0;
    for (int unsigned r = 0; r < 15; r++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (live_d[j] && (wa_d[j] == AW'(r))) pending_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;
`else
  assign pending = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a queue model.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;

  typedef struct {
    bit          live;
    bit [AW-1:0] wa;
    bit [DW-1:0] wd;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [2:0]  fifo_cnt;
  logic [14:0] pending;

  wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .fifo_cnt (fifo_cnt),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ent_t        q[$];
  bit          m_we;
  bit [AW-1:0] m_wa;
  bit [DW-1:0] m_wd;
  bit [14:0]   m_pend;
  bit [DW-1:0] rf [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pwe, input bit [3:0] pwa, input bit [31:0] pwd,
                       input bit sv, input bit [3:0] swa, input bit [31:0] swd);
    bus.pri_we    = pwe;
    bus.pri_wa    = pwa;
    bus.pri_wd    = pwd;
    bus.sec_valid = sv;
    bus.sec_wa    = swa;
    bus.sec_wd    = swd;
  endtask

  // Called #1 after a posedge with inputs already applied; returns #1 after the next posedge.
  task automatic tick();
    bit   exp_ready;
    bit   hs;
    ent_t h;
    ent_t e;
    #1;
    exp_ready = !reset && (q.size() < DEPTH);
    check("sec_ready", bus.sec_ready, exp_ready);
    hs = bus.sec_valid && exp_ready;
    if (reset) begin
      q.delete();
      m_we = 0; m_wa = '0; m_wd = '0;
    end else begin
      if (bus.pri_we && bus.pri_wa != 4'd15) begin
        foreach (q[k]) if (q[k].wa == bus.pri_wa) q[k].live = 0;
        m_we = 1; m_wa = bus.pri_wa; m_wd = bus.pri_wd;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        m_we = h.live; m_wa = h.wa; m_wd = h.wd;
      end else begin
        m_we = 0;
      end
      if (hs) begin
        e.live = (bus.sec_wa != 4'd15);
        e.wa   = bus.sec_wa;
        e.wd   = bus.sec_wd;
        q.push_back(e);
      end
      if (m_we) rf[m_wa] = m_wd;
    end
    m_pend = '0;
`ifdef WB_SCOREBOARD_EN
    foreach (q[k]) if (q[k].live && q[k].wa != 4'd15) m_pend[q[k].wa] = 1'b1;
`endif
    @(posedge clk);
    #1;
    check("we3", bus.we3, m_we);
    check("wa3", bus.wa3, m_wa);
    check("wd3", bus.wd3, m_wd);
    check("fifo_cnt", fifo_cnt, q.size());
    check("pending", pending, m_pend);
    check("no_r15_write", bus.we3 && (bus.wa3 == 4'd15), 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    repeat (2) tick();
    reset = 1'b0;

    // T2 primary write
    drive(1, 3, 32'hA5A5_0001, 0, 0, 0);
    tick();
    check("T2_we3", bus.we3, 1'b1);
    check("T2_wa3", bus.wa3, 4'd3);
    check("T2_wd3", bus.wd3, 32'hA5A5_0001);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("T2_idle_we3", bus.we3, 1'b0);

    // T1 reset in the middle of traffic
    drive(1, 8, 32'h8, 1, 1, 32'h11); tick();
    drive(1, 8, 32'h8, 1, 2, 32'h22); tick();
    check("T1_cnt_before", fifo_cnt, 3'd2);
    reset = 1'b1;
    drive(1, 8, 32'h8, 1, 6, 32'h66);
    tick();
    check("T1_ready_in_reset", bus.sec_ready, 1'b0);
    tick();
    check("T1_cnt_reset", fifo_cnt, 3'd0);
    check("T1_wd3_reset", bus.wd3, 32'h0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // T3 fill while primary busy, then drain in order
    for (int k = 1; k <= 4; k++) begin
      drive(1, 8, 32'h8, 1, 4'(k), 32'(k * 'h11));
      tick();
    end
    drive(1, 8, 32'h8, 0, 0, 0);
    tick();
    check("T3_full_cnt", fifo_cnt, 3'd4);
    check("T3_full_ready", bus.sec_ready, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("T3_drain_wa3", bus.wa3, 4'(k));
      check("T3_drain_wd3", bus.wd3, 32'(k * 'h11));
      if (k == 1) check("T3_ready_after_pop", bus.sec_ready, 1'b1);
    end

    // T4 WAW kill
    drive(0, 0, 0, 1, 5, 32'h55); tick();
    drive(1, 5, 32'h99, 0, 0, 0); tick();
    check("T4_wd3", bus.wd3, 32'h99);
    check("T4_cnt1", fifo_cnt, 3'd1);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("T4_killed_we3", bus.we3, 1'b0);
    check("T4_cnt0", fifo_cnt, 3'd0);

    // T5 R15 filtering on both sources
    drive(1, 15, 32'hBEEF, 1, 15, 32'hDEAD); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    check("T5_we3", bus.we3, 1'b0);
    check("T5_cnt", fifo_cnt, 3'd0);

    // T6 scoreboard
    drive(1, 9, 32'h9, 1, 2, 32'h2); tick();
`ifdef WB_SCOREBOARD_EN
    check("T6_pending_set", pending, 15'h0004);
`else
    check("T6_pending_off", pending, 15'h0000);
`endif
    drive(0, 0, 0, 0, 0, 0); tick();
    check("T6_pending_clr", pending, 15'h0000);

    // Random traffic; narrow address range to provoke kills
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 99) < 55, 4'($urandom_range(0, 5) == 0 ? 15 : $urandom_range(0, 5)),
            $urandom, $urandom_range(0, 99) < 60,
            4'($urandom_range(0, 7) == 0 ? 15 : $urandom_range(0, 5)), $urandom);
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) tick();
    check("final_cnt", fifo_cnt, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
